// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with optional hardwired R0, write bypass and busy scoreboard
module regfile_mp #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W = 16,
  parameter int ZERO_REG = 0,
  parameter int BYPASS = 1,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rd_addr0,
  input  logic [ADDR_W-1:0]   rd_addr1,
  output logic [DATA_W-1:0]   rd_data0,
  output logic [DATA_W-1:0]   rd_data1,
  output logic                rd_busy0,
  output logic                rd_busy1,
  input  logic                wr_en0,
  input  logic [ADDR_W-1:0]   wr_addr0,
  input  logic [DATA_W-1:0]   wr_data0,
  input  logic                wr_en1,
  input  logic [ADDR_W-1:0]   wr_addr1,
  input  logic [DATA_W-1:0]   wr_data1,
  input  logic                alloc_en,
  input  logic [ADDR_W-1:0]   alloc_reg,
  output logic [NUM_REGS-1:0] busy_vec
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy, busy_nxt;
  logic we0, we1, alc;
  logic [1:0][ADDR_W-1:0] ra;
  logic [1:0][DATA_W-1:0] rd;
  logic [1:0] rb;
  assign we0 = wr_en0 && reset && !(ZERO_REG != 0 && wr_addr0 == '0);
  assign we1 = wr_en1 && reset && !(ZERO_REG != 0 && wr_addr1 == '0);
  assign alc = alloc_en && reset && !(ZERO_REG != 0 && alloc_reg == '0);
  // writes clear their register's busy bit, then a same-cycle alloc sets it again
  always_comb begin
    busy_nxt = (busy & ~((NUM_REGS'(we0) << wr_addr0) | (NUM_REGS'(we1) << wr_addr1)))
             | (NUM_REGS'(alc) << alloc_reg);
  end
  // storage and scoreboard; port 1 is assigned last so it wins a same-address collision
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (we0) regs[wr_addr0] <= wr_data0;
      if (we1) regs[wr_addr1] <= wr_data1;
      busy <= busy_nxt;
    end
  end
  assign ra = {rd_addr1, rd_addr0};
  for (genvar k = 0; k < 2; k++) begin : g_rd
    logic h0, h1, z;
    assign h0 = BYPASS != 0 && we0 && wr_addr0 == ra[k];
    assign h1 = BYPASS != 0 && we1 && wr_addr1 == ra[k];
    assign z = !reset || (ZERO_REG != 0 && ra[k] == '0);
    assign rd[k] = z ? '0 : h1 ? wr_data1 : h0 ? wr_data0 : regs[ra[k]];
    assign rb[k] = !z && busy[ra[k]] && !h0 && !h1;
  end
  assign rd_data0 = rd[0];
  assign rd_data1 = rd[1];
  assign rd_busy0 = rb[0];
  assign rd_busy1 = rb[1];
  assign busy_vec = busy;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized check of two regfile_mp builds against a behavioural model
module tb_regfile_mp;
  logic clk, rst;
  logic [3:0] ra0, ra1, wa0, wa1, ar;
  logic [15:0] wd0, wd1, qd0, qd1, bv;
  logic we0, we1, al, qb0, qb1;
  logic [4:0] b_ra0, b_ra1, b_wa0, b_wa1, b_ar;
  logic [31:0] b_wd0, b_wd1, b_qd0, b_qd1, b_bv;
  logic b_we0, b_we1, b_al, b_qb0, b_qb1;
  logic [15:0] ma [16];
  logic ba [16];
  logic [31:0] mb [32];
  logic bb [32];
  int n = 0, err = 0;

  regfile_mp #(.NUM_REGS(16), .DATA_W(16), .ZERO_REG(0), .BYPASS(1)) dut_a (
    .clk(clk), .reset(rst), .rd_addr0(ra0), .rd_addr1(ra1), .rd_data0(qd0), .rd_data1(qd1),
    .rd_busy0(qb0), .rd_busy1(qb1), .wr_en0(we0), .wr_addr0(wa0), .wr_data0(wd0),
    .wr_en1(we1), .wr_addr1(wa1), .wr_data1(wd1), .alloc_en(al), .alloc_reg(ar), .busy_vec(bv));

  regfile_mp #(.NUM_REGS(32), .DATA_W(32), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .reset(rst), .rd_addr0(b_ra0), .rd_addr1(b_ra1), .rd_data0(b_qd0), .rd_data1(b_qd1),
    .rd_busy0(b_qb0), .rd_busy1(b_qb1), .wr_en0(b_we0), .wr_addr0(b_wa0), .wr_data0(b_wd0),
    .wr_en1(b_we1), .wr_addr1(b_wa1), .wr_data1(b_wd1), .alloc_en(b_al), .alloc_reg(b_ar), .busy_vec(b_bv));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] a_rd(input logic [3:0] r);
    if (!rst) return '0;
    if (we1 && wa1 == r) return wd1;
    if (we0 && wa0 == r) return wd0;
    return ma[r];
  endfunction

  function automatic logic a_bz(input logic [3:0] r);
    if (!rst || (we1 && wa1 == r) || (we0 && wa0 == r)) return 1'b0;
    return ba[r];
  endfunction

  function automatic logic [31:0] b_rd(input logic [4:0] r);
    return (!rst || r == 0) ? 32'h0 : mb[r];
  endfunction

  function automatic logic [15:0] a_bv();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = ba[i];
    return v;
  endfunction

  function automatic logic [31:0] b_bvm();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = bb[i];
    return v;
  endfunction

  task automatic clr_model();
    for (int i = 0; i < 16; i++) begin ma[i] = '0; ba[i] = 1'b0; end
    for (int i = 0; i < 32; i++) begin mb[i] = '0; bb[i] = 1'b0; end
  endtask

  task automatic upd_model();
    if (we0) begin ma[wa0] = wd0; ba[wa0] = 1'b0; end
    if (we1) begin ma[wa1] = wd1; ba[wa1] = 1'b0; end
    if (al) ba[ar] = 1'b1;
    if (b_we0 && b_wa0 != 0) begin mb[b_wa0] = b_wd0; bb[b_wa0] = 1'b0; end
    if (b_we1 && b_wa1 != 0) begin mb[b_wa1] = b_wd1; bb[b_wa1] = 1'b0; end
    if (b_al && b_ar != 0) bb[b_ar] = 1'b1;
  endtask

  task automatic tick();
    #1;
    if (!rst) clr_model();
    chk("a_rd0", qd0, a_rd(ra0));
    chk("a_rd1", qd1, a_rd(ra1));
    chk("a_busy0", qb0, a_bz(ra0));
    chk("a_busy1", qb1, a_bz(ra1));
    chk("a_busy_vec", bv, a_bv());
    chk("b_rd0", b_qd0, b_rd(b_ra0));
    chk("b_rd1", b_qd1, b_rd(b_ra1));
    chk("b_busy0", b_qb0, rst ? bb[b_ra0] : 1'b0);
    chk("b_busy1", b_qb1, rst ? bb[b_ra1] : 1'b0);
    chk("b_busy_vec", b_bv, b_bvm());
    if (rst) upd_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; al = 0; b_we0 = 0; b_we1 = 0; b_al = 0;
  endtask

  function automatic logic [3:0] pa();
    return $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
  endfunction

  function automatic logic [4:0] pb();
    case ($urandom_range(0, 3))
      0: return 5'($urandom_range(0, 3));
      1: return 5'd31;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic rnd();
    ra0 = pa(); ra1 = pa(); wa0 = pa(); wa1 = pa(); ar = pa();
    we0 = 1'($urandom); we1 = 1'($urandom); al = 1'($urandom);
    wd0 = 16'($urandom); wd1 = 16'($urandom);
    b_ra0 = pb(); b_ra1 = pb(); b_wa0 = pb(); b_wa1 = pb(); b_ar = pb();
    b_we0 = 1'($urandom); b_we1 = 1'($urandom); b_al = 1'($urandom);
    b_wd0 = $urandom; b_wd1 = $urandom;
  endtask

  initial begin
    rst = 0;
    clr_model();
    repeat (3) begin rnd(); tick(); end
    rst = 1;
    idle();
    for (int i = 0; i < 16; i++) begin
      ra0 = 4'(i); ra1 = 4'(15 - i); b_ra0 = 5'(2 * i); b_ra1 = 5'(2 * i + 1);
      tick();
    end
    chk("rst_busy_vec", {16'h0, bv}, 32'h0);
    we0 = 1; wa0 = 5; wd0 = 16'hA5A5; b_we0 = 1; b_wa0 = 5; b_wd0 = 32'hA5A5;
    tick();
    idle(); ra0 = 5; b_ra0 = 5;
    #1 chk("wr5", {16'h0, qd0}, 32'hA5A5);
    we0 = 1; wa0 = 3; wd0 = 16'h1111; we1 = 1; wa1 = 3; wd1 = 16'h2222;
    b_we0 = 1; b_wa0 = 3; b_wd0 = 32'h1111; b_we1 = 1; b_wa1 = 3; b_wd1 = 32'h2222;
    tick();
    idle(); ra0 = 3; b_ra0 = 3;
    #1 chk("dual_wr3", {16'h0, qd0}, 32'h2222);
    chk("b_dual_wr3", b_qd0, 32'h2222);
    tick();
    al = 1; ar = 7; b_al = 1; b_ar = 7;
    tick();
    idle(); we1 = 1; wa1 = 7; wd1 = 16'h00FF; ra1 = 7; b_we1 = 1; b_wa1 = 7; b_wd1 = 32'h00FF; b_ra1 = 7;
    #1 chk("byp_rd1", {16'h0, qd1}, 32'h00FF);
    chk("byp_busy1", {31'h0, qb1}, 32'h0);
    chk("nobyp_rd1", b_qd1, 32'h0);
    tick();
    idle();
    #1 chk("nobyp_next", b_qd1, 32'h00FF);
    tick();
    al = 1; ar = 9; b_al = 1; b_ar = 9; ra0 = 9; b_ra0 = 9;
    tick();
    idle();
    #1 chk("alloc9", {31'h0, bv[9]}, 32'h1);
    we0 = 1; wa0 = 9; wd0 = 16'h0909; b_we0 = 1; b_wa0 = 9; b_wd0 = 32'h0909;
    tick();
    idle();
    #1 chk("wr9_clr", {31'h0, bv[9]}, 32'h0);
    al = 1; ar = 9; we1 = 1; wa1 = 9; wd1 = 16'h9999; b_al = 1; b_ar = 9; b_we1 = 1; b_wa1 = 9; b_wd1 = 32'h9999;
    tick();
    idle();
    #1 chk("alloc_wr9", {15'h0, bv[9], qd0}, {15'h0, 1'b1, 16'h9999});
    we0 = 1; wa0 = 0; wd0 = 16'hFFFF; b_we0 = 1; b_wa0 = 0; b_wd0 = 32'hFFFF;
    b_we1 = 1; b_wa1 = 31; b_wd1 = 32'hDEADBEEF; b_al = 1; b_ar = 0; b_ra0 = 0; b_ra1 = 31;
    tick();
    idle();
    #1 chk("zero_r0", b_qd0, 32'h0);
    chk("zero_busy0", {31'h0, b_bv[0]}, 32'h0);
    chk("r31", b_qd1, 32'hDEADBEEF);
    tick();
    we0 = 1; wa0 = 2; wd0 = 16'h1234; al = 1; ar = 4; b_we0 = 1; b_wa0 = 2; b_wd0 = 32'h1234; b_al = 1; b_ar = 4;
    tick();
    idle(); ra0 = 2; b_ra0 = 2;
    #1 chk("pre_rst_r2", {16'h0, qd0}, 32'h1234);
    rst = 0;
    #1 chk("async_rst_r2", {16'h0, qd0}, 32'h0);
    chk("async_rst_bv", {16'h0, bv}, 32'h0);
    tick();
    rst = 1;
    for (int c = 0; c < 3000; c++) begin
      rnd();
      if (c % 500 == 499) rst = 0;
      tick();
      rst = 1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule
